// File: rtl/dac_pkg.sv
// ============================================================================
// dac_pkg : shared types and helpers for the DAC SPI transmitter
// Revision: 1.0
// ============================================================================
`default_nettype none

package dac_pkg;

  localparam int FRAME_BITS = 24;

`ifdef DAC_LDAC_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_LDAC  = 2'd3
  } dac_state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } dac_state_t;
`endif

  // Two's complement to offset binary: flipping the sign bit maps -32768..32767 onto 0..65535.
  function automatic logic [15:0] to_offset_binary(input logic signed [15:0] v);
    return {~v[15], v[14:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sclk_tick_gen.sv
// ============================================================================
// sclk_tick_gen : one-cycle tick every CLK_DIV clocks while enabled
// Revision: 1.0
// ============================================================================
`default_nettype none

module sclk_tick_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!en_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dac_spi_tx.sv
// ============================================================================
// dac_spi_tx : serialises 16-bit samples into 24-bit SPI mode-0 DAC frames
// Optional LDAC strobe after each frame: define DAC_LDAC_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module dac_spi_tx
  import dac_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 2,
  parameter logic [7:0]  CMD     = 8'h30,
  parameter int unsigned LDAC_W  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        valid,
  output logic        ready,
  output logic        dac_cs_n,
  output logic        dac_sclk,
`ifdef DAC_LDAC_EN
  output logic        dac_ldac_n,
`endif
  output logic        dac_mosi
);

  // One counter serves both the CS gap and the LDAC pulse, so size it for the larger.
  localparam int unsigned WAIT_MAX = (CS_GAP > LDAC_W) ? CS_GAP : LDAC_W;
  localparam int          WAIT_W   = $clog2(WAIT_MAX + 1);

  dac_state_t              state_q;
  logic [FRAME_BITS-1:0]   frame_q;
  logic [4:0]              bit_cnt_q;
  logic [WAIT_W-1:0]       wait_cnt_q;
  logic                    sclk_q;
  logic                    cs_n_q;
  logic                    ready_q;
  logic                    sclk_tick;
`ifdef DAC_LDAC_EN
  logic                    ldac_n_q;
`endif

  sclk_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q == S_SHIFT),
    .tick_o (sclk_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      ready_q    <= 1'b1;
`ifdef DAC_LDAC_EN
      ldac_n_q   <= 1'b1;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid && ready_q) begin
            frame_q   <= {CMD, to_offset_binary(value)};
            bit_cnt_q <= 5'(FRAME_BITS - 1);
            cs_n_q    <= 1'b0;
            sclk_q    <= 1'b0;
            ready_q   <= 1'b0;
            state_q   <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (sclk_tick) begin
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              // Zeros shift in, so MOSI is already low once the last bit leaves.
              sclk_q  <= 1'b0;
              frame_q <= {frame_q[FRAME_BITS-2:0], 1'b0};
              if (bit_cnt_q == 5'd0) begin
                cs_n_q     <= 1'b1;
                wait_cnt_q <= '0;
                state_q    <= S_GAP;
              end else begin
                bit_cnt_q <= bit_cnt_q - 5'd1;
              end
            end
          end
        end

        S_GAP: begin
          if (wait_cnt_q == WAIT_W'(CS_GAP - 1)) begin
            wait_cnt_q <= '0;
`ifdef DAC_LDAC_EN
            ldac_n_q   <= 1'b0;
            state_q    <= S_LDAC;
`else
            ready_q    <= 1'b1;
            state_q    <= S_IDLE;
`endif
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end

`ifdef DAC_LDAC_EN
        S_LDAC: begin
          if (wait_cnt_q == WAIT_W'(LDAC_W - 1)) begin
            wait_cnt_q <= '0;
            ldac_n_q   <= 1'b1;
            ready_q    <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
`endif

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready      = ready_q;
  assign dac_cs_n   = cs_n_q;
  assign dac_sclk   = sclk_q;
  assign dac_mosi   = frame_q[FRAME_BITS-1];
`ifdef DAC_LDAC_EN
  assign dac_ldac_n = ldac_n_q;
`endif

endmodule

`default_nettype wire
